// File: rtl/whac_pkg.sv
// Shared Whac-A-Mole constants used by rng, mole_spawner and the scorer.
package whac_pkg;

    localparam int unsigned NUM_HOLES         = 18;
    localparam int unsigned IDX_W             = $clog2(NUM_HOLES);
    localparam int unsigned CLK_HZ            = 50_000_000;
    localparam int unsigned SPAWN_PERIOD_DEF  = CLK_HZ / 2;
    localparam int unsigned MOLE_LIFETIME_DEF = CLK_HZ;
    localparam int unsigned MAX_ACTIVE_DEF    = 3;

    // Spawner control states
    localparam logic [0:0] ST_PAUSED = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;

endpackage

// File: rtl/mole_slot.sv
// One hole: occupied flag plus a lifetime timer that counts down while the game runs.
module mole_slot #(
    parameter int unsigned MOLE_LIFETIME = whac_pkg::MOLE_LIFETIME_DEF,
    parameter int unsigned TIMER_W       = $clog2(MOLE_LIFETIME + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic whack_hit,
    input  logic tick_en,
    input  logic clear,
    output logic up,
    output logic expire
);

    logic               up_q, up_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    // A whack landing on the final cycle takes precedence over the expiry.
    assign expire = up_q & tick_en & ~whack_hit & ~clear & (timer_q == TIMER_W'(1));
    assign up     = up_q;

    always_comb begin
        up_d    = up_q;
        timer_d = timer_q;
        if (clear) begin
            up_d    = 1'b0;
            timer_d = '0;
        end else if (load) begin
            up_d    = 1'b1;
            timer_d = TIMER_W'(MOLE_LIFETIME);
        end else if (whack_hit) begin
            up_d    = 1'b0;
            timer_d = '0;
        end else if (up_q && tick_en) begin
            timer_d = timer_q - TIMER_W'(1);
            if (timer_q == TIMER_W'(1)) begin
                up_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_q    <= 1'b0;
            timer_q <= '0;
        end else begin
            up_q    <= up_d;
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/mole_spawner.sv
// Turns rng hole indices into timed mole appearances and resolves whacks into
// hit/miss strobes for the scorer.
module mole_spawner
    import whac_pkg::*;
#(
    parameter int unsigned NUM_HOLES     = whac_pkg::NUM_HOLES,
    parameter int unsigned IDX_W         = $clog2(NUM_HOLES),
    parameter int unsigned SPAWN_PERIOD  = SPAWN_PERIOD_DEF,
    parameter int unsigned MOLE_LIFETIME = MOLE_LIFETIME_DEF,
    parameter int unsigned MAX_ACTIVE    = MAX_ACTIVE_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic                           clear,
    input  logic [IDX_W-1:0]               random_value,
    input  logic                           whack_valid,
    input  logic [IDX_W-1:0]               whack_idx,
    output logic [NUM_HOLES-1:0]           mole_mask,
    output logic [$clog2(NUM_HOLES+1)-1:0] active_count,
    output logic                           hit_pulse,
    output logic                           miss_pulse
);

    localparam int unsigned ACNT_W = $clog2(NUM_HOLES + 1);
    localparam int unsigned CNT_W  = $clog2(SPAWN_PERIOD);

    logic [0:0]           state;
    logic                 run;
    logic [CNT_W-1:0]     spawn_cnt_q, spawn_cnt_d;
    logic                 spawn_tick;
    logic                 spawn_ok;
    logic [NUM_HOLES-1:0] up_vec, load_vec, hit_vec, expire_vec, mask_next;
    logic [ACNT_W-1:0]    count_q, count_d;
    logic                 hit_q, hit_d;
    logic                 miss_q, miss_d;

    // The mode follows enable directly so a resume takes effect in the same cycle.
    assign state = enable ? ST_RUN : ST_PAUSED;
    assign run   = (state == ST_RUN);

    assign spawn_tick = run && (spawn_cnt_q == CNT_W'(SPAWN_PERIOD - 1));
    assign spawn_ok   = spawn_tick && (32'(random_value) < NUM_HOLES)
                        && (count_q < ACNT_W'(MAX_ACTIVE));

    always_comb begin
        load_vec = '0;
        hit_vec  = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            load_vec[i] = spawn_ok && (random_value == IDX_W'(i)) && !up_vec[i];
            hit_vec[i]  = run && whack_valid && (whack_idx == IDX_W'(i)) && up_vec[i];
        end
    end

    for (genvar g = 0; g < NUM_HOLES; g++) begin : g_slot
        mole_slot #(
            .MOLE_LIFETIME(MOLE_LIFETIME)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load_vec[g]),
            .whack_hit(hit_vec[g]),
            .tick_en  (run),
            .clear    (clear),
            .up       (up_vec[g]),
            .expire   (expire_vec[g])
        );
    end

    always_comb begin
        spawn_cnt_d = spawn_cnt_q;
        if (clear) begin
            spawn_cnt_d = '0;
        end else if (run) begin
            spawn_cnt_d = spawn_tick ? '0 : spawn_cnt_q + CNT_W'(1);
        end
    end

    // Registered popcount tracks the mask the slots will hold after this edge.
    always_comb begin
        mask_next = clear ? '0 : ((up_vec | load_vec) & ~hit_vec & ~expire_vec);
        count_d   = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            count_d = count_d + ACNT_W'(mask_next[i]);
        end
    end

    assign hit_d  = !clear && (|hit_vec);
    assign miss_d = !clear && (|expire_vec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spawn_cnt_q <= '0;
            count_q     <= '0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
        end else begin
            spawn_cnt_q <= spawn_cnt_d;
            count_q     <= count_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
        end
    end

    assign mole_mask    = up_vec;
    assign active_count = count_q;
    assign hit_pulse    = hit_q;
    assign miss_pulse   = miss_q;

endmodule

// File: doc/mole_spawner.md
Name: mole_spawner

Overview:
Consumes the hole index produced by the rng stage and turns it into timed mole appearances for the Whac-A-Mole game. At a fixed spawn cadence it samples random_value and raises a mole in that hole for a bounded lifetime. It also resolves player whacks into hit or miss strobes. It sits between rng and the scoring/display logic; mole_mask drives the hole LEDs and the strobes feed the scorer.

Parameters:
NUM_HOLES, 18, number of holes; must equal the rng MAX_VALUE.
IDX_W, $clog2(NUM_HOLES), width of hole index (5 for default).
SPAWN_PERIOD, 25_000_000, cycles between spawn attempts; must be >= 2.
MOLE_LIFETIME, 50_000_000, cycles a mole stays up if not whacked; must be >= 2.
MAX_ACTIVE, 3, maximum simultaneous moles; range 1..NUM_HOLES.

Ports:
clk  input  1  system clock, 50 MHz, rising edge.
rst_n  input  1  asynchronous active-low reset.
enable  input  1  game running; low = pause.
clear  input  1  synchronous game restart; drops all moles.
random_value  input  IDX_W  hole index from rng, sampled only at spawn ticks.
whack_valid  input  1  one-cycle player whack strobe.
whack_idx  input  IDX_W  hole being whacked.
mole_mask  output  NUM_HOLES  bit i = mole up in hole i.
active_count  output  $clog2(NUM_HOLES+1)  popcount of mole_mask, registered.
hit_pulse  output  1  one cycle: whack landed on an up mole.
miss_pulse  output  1  one cycle: a mole expired unwhacked.

Behaviour:
- Single clock clk; reset is asynchronous and active-low (rst_n). While rst_n=0: mole_mask=0, active_count=0, hit_pulse=0, miss_pulse=0, spawn counter=0, all lifetime timers=0. Reset asserted mid-operation clears everything immediately, with no strobes.
- Control FSM: PAUSED (enable=0) and RUN (enable=1). Entering RUN does not reset the spawn counter. Resume continues from the held count.
- PAUSED: spawn counter, lifetime timers and mole_mask frozen. Whacks ignored. Strobes 0.
- RUN spawn counter: counts 0..SPAWN_PERIOD-1 and wraps. The spawn tick is the cycle in which count==SPAWN_PERIOD-1.
- Spawn attempt on a tick: sample random_value (v). Spawn if all of the following hold: v < NUM_HOLES, mole_mask[v]==0, and active_count < MAX_ACTIVE. Otherwise the attempt is silently dropped; there is no retry until the next tick.
- On spawn: mole_mask[v] is set on the tick edge, timer[v] is loaded with MOLE_LIFETIME, and active_count is updated on the same edge.
- Lifetime: each up mole's timer decrements by 1 per RUN cycle. When it reaches 0, the bit clears and miss_pulse=1 for exactly that cycle. Timer loaded with L means the bit is high for exactly L RUN cycles.
- Whack: whack_valid is evaluated against the current (pre-edge) mole_mask.
  - If whack_idx < NUM_HOLES and the bit is set: clear the bit, zero its timer, and assert hit_pulse on the next cycle (1-cycle latency).
  - Otherwise there is no effect and no strobe.
- Simultaneous events:
  - Whack and expiry on the same hole in the same cycle: the hit wins, hit_pulse=1, miss_pulse=0.
  - Spawn tick and whack on an empty hole v in the same cycle: the spawn happens and no hit is recorded.
  - Whack clearing a mole in the same cycle as a spawn tick: the spawn uses the pre-edge active_count.
  - Two expiries cannot coincide, because spawns are >= 2 cycles apart and lifetimes are equal.
- clear (RUN or PAUSED): on the next edge mole_mask=0, timers=0, spawn counter=0, no strobes. clear has priority over spawn, whack and expiry.
- Widths: timers use $clog2(MOLE_LIFETIME+1) bits and the spawn counter uses $clog2(SPAWN_PERIOD) bits. All comparisons are unsigned.

Decomposition:
- Shared package whac_pkg: NUM_HOLES, IDX_W, CLK_HZ, and default SPAWN_PERIOD/MOLE_LIFETIME constants, also used by rng and the scorer.
- Sub-module mole_slot, generated NUM_HOLES times:
  - Inputs: load, whack_hit, tick_en, clear.
  - Outputs: up, expire.
  - Holds one lifetime timer and one occupied flag.
- The top level holds the FSM, spawn counter, acceptance check, popcount and strobe registers.

Test Plan:
- Reset: run with 2 moles up, pulse rst_n low between edges -> mole_mask=0 and active_count=0 before the next edge; no strobes.
- Spawn (SPAWN_PERIOD=4, MOLE_LIFETIME=10, MAX_ACTIVE=2): enable=1 from cycle 0, random_value=5 -> mole_mask=18'h00020 after the 4th edge, active_count=1.
- Expiry: same setup, no whack -> bit 5 high for exactly 10 cycles, miss_pulse=1 for one cycle as it clears, active_count returns to 0.
- Hit: whack_idx=5 with whack_valid 3 cycles after spawn -> bit 5 clears at that edge, hit_pulse high the next cycle, no later miss_pulse; whack_idx=6 (empty) -> no strobe.
- Rejection and edge cases, one check each:
  - random_value=20 -> no spawn.
  - random_value=5 while hole 5 is up -> no change.
  - Two moles up with MAX_ACTIVE=2 -> third tick dropped.
  - Whack on the exact expiry cycle -> hit_pulse=1, miss_pulse=0.
- Pause/clear: enable=0 for 7 cycles with a mole at timer 6 -> mask and timer held; on resume it expires 6 RUN cycles later; clear=1 -> mask=0 next edge, no miss_pulse.
